// File: rtl/if_prefetch_buffer.sv
// Sequential instruction prefetcher that sits between the instruction memory port and IF.
// Keeps fetched {addr, data} pairs in a small in-order FIFO; a redirect flushes it and discards in-flight responses.
module if_prefetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     req_addr_reg, req_addr_next;
  logic            stale_reg, stale_next;
  logic [31:0]     resp_addr_reg;
  logic [CW-1:0]   fifo_count_reg, fifo_count_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   discard_reg, discard_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [31:0]     entry_addr [DEPTH];
  logic [31:0]     entry_data [DEPTH];

  logic [31:0]     target;
  logic            gnt_fire, gnt_keep, push, pop, credit_next;
  logic [CW:0]     total_next;

  assign target        = branch_addr_i & 32'hFFFF_FFFC;
  assign gnt_fire      = (state_reg == REQ) && instr_gnt_i;
  // A grant is only useful if its address was captured after the last redirect.
  assign gnt_keep      = gnt_fire && !stale_reg && !branch_i;
  assign push          = instr_rvalid_i && (discard_reg == '0) && !branch_i;
  assign fetch_valid_o = (fifo_count_reg != '0);
  assign pop           = fetch_valid_o && fetch_ready_i && !branch_i;

  assign instr_req_o   = (state_reg == REQ);
  assign instr_addr_o  = (state_reg == REQ) ? req_addr_reg : addr_reg;
  assign fetch_addr_o  = entry_addr[rd_ptr_reg];
  assign fetch_rdata_o = entry_data[rd_ptr_reg];
  assign busy_o        = (outstanding_reg != '0) || (discard_reg != '0);

  always_comb begin
    fifo_count_next  = fifo_count_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (branch_i) begin
      // Everything still owed by the bus becomes a discard; the branch-cycle rvalid retires one of them.
      fifo_count_next  = '0;
      outstanding_next = '0;
      discard_next     = discard_reg + outstanding_reg + CW'(gnt_fire) - CW'(instr_rvalid_i);
    end else begin
      fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
      outstanding_next = outstanding_reg + CW'(gnt_keep) - CW'(push);
      discard_next     = discard_reg + CW'(gnt_fire && stale_reg)
                       - CW'(instr_rvalid_i && (discard_reg != '0));
    end
  end

  always_comb begin
    addr_next = addr_reg;
    if (branch_i)
      addr_next = target;
    else if (gnt_keep)
      addr_next = addr_reg + 32'd4;
  end

  // Credit is judged on next-cycle occupancy so a pop lets the following cycle request.
  assign total_next  = (CW+1)'(fifo_count_next) + (CW+1)'(outstanding_next) + (CW+1)'(discard_next);
  assign credit_next = total_next < (CW+1)'(DEPTH);

  always_comb begin
    state_next    = state_reg;
    req_addr_next = req_addr_reg;
    stale_next    = stale_reg;
    case (state_reg)
      IDLE: begin
        if (req_i && credit_next) begin
          state_next    = REQ;
          req_addr_next = addr_next;
          stale_next    = 1'b0;
        end
      end
      REQ: begin
        if (instr_gnt_i) begin
          stale_next = 1'b0;
          if (req_i && credit_next)
            req_addr_next = addr_next;
          else
            state_next = IDLE;
        end else if (branch_i) begin
          stale_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      req_addr_reg    <= '0;
      stale_reg       <= 1'b0;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      req_addr_reg    <= req_addr_next;
      stale_reg       <= stale_next;
      fifo_count_reg  <= fifo_count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_addr_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
      end
    end else if (branch_i) begin
      resp_addr_reg <= target;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      if (push) begin
        entry_addr[wr_ptr_reg] <= resp_addr_reg;
        entry_data[wr_ptr_reg] <= instr_rdata_i;
        wr_ptr_reg             <= wr_ptr_reg + AW'(1);
        resp_addr_reg          <= resp_addr_reg + 32'd4;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: a random-latency memory plus an epoch/queue model of what
// IF should see, driven through directed scenarios and a randomized run.
module tb_if_prefetch_buffer;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;

  if_prefetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int tag; int rdy; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  pend_t       mem_q[$];      // granted requests the memory still owes
  ent_t        fifo_q[$];     // what IF should currently have buffered
  ent_t        pop_log[$];    // deliveries observed since the last clear
  int          checks = 0;
  int          errors = 0;
  int          epoch, cyc, gnt_pct, rv_pct;
  logic        stale_pend, hold_flag;
  logic [31:0] hold_addr, exp_req_addr, exp_fetch_addr;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    mem_q.delete();
    fifo_q.delete();
    pop_log.delete();
    epoch = 0;
    stale_pend = 1'b0;
    hold_flag = 1'b0;
    hold_addr = '0;
    exp_req_addr = '0;
    exp_fetch_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_req"}, instr_req_o, 0);
    check_value({tag, "_addr"}, instr_addr_o, 0);
    check_value({tag, "_valid"}, fetch_valid_o, 0);
    check_value({tag, "_rdata"}, fetch_rdata_o, 0);
    check_value({tag, "_faddr"}, fetch_addr_o, 0);
    check_value({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    clear_model();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("reset");
  endtask

  // One clock: memory answers, model advances at the edge, outputs checked on the falling edge.
  task automatic cycle();
    pend_t       p;
    ent_t        e;
    logic        br, s_req, s_valid;
    logic [31:0] tgt, s_addr, s_faddr, s_fdata;
    int          tag;
    s_req   = instr_req_o;
    s_addr  = instr_addr_o;
    s_valid = fetch_valid_o;
    s_faddr = fetch_addr_o;
    s_fdata = fetch_rdata_o;
    instr_gnt_i    = s_req && (int'($urandom_range(99)) < gnt_pct);
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].rdy <= cyc && int'($urandom_range(99)) < rv_pct) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_q[0].addr + 32'hA0;
      end
    end
    br  = branch_i;
    tgt = branch_addr_i & 32'hFFFF_FFFC;
    @(posedge clk_i);
    if (!br && s_valid && fetch_ready_i) begin
      e.addr = s_faddr;
      e.data = s_fdata;
      pop_log.push_back(e);
      $display("%0t fetch addr=0x%08h data=0x%08h", $time, s_faddr, s_fdata);
      check_value("fetch_seq", s_faddr, exp_fetch_addr);
      exp_fetch_addr += 32'd4;
      if (fifo_q.size() > 0) e = fifo_q.pop_front();
    end
    if (instr_rvalid_i) begin
      p = mem_q.pop_front();
      if (!br && p.tag == epoch) begin
        e.addr = p.addr;
        e.data = p.addr + 32'hA0;
        fifo_q.push_back(e);
      end
    end
    if (s_req && instr_gnt_i) begin
      if (br || stale_pend) begin
        tag = -1;
      end else begin
        tag = epoch;
        check_value("req_addr", s_addr, exp_req_addr);
        exp_req_addr += 32'd4;
      end
      p.addr = s_addr;
      p.tag  = tag;
      p.rdy  = cyc + 1;
      mem_q.push_back(p);
      stale_pend = 1'b0;
    end
    hold_flag = s_req && !instr_gnt_i;
    hold_addr = s_addr;
    if (br) begin
      fifo_q.delete();
      epoch++;
      exp_req_addr   = tgt;
      exp_fetch_addr = tgt;
      if (s_req && !instr_gnt_i) stale_pend = 1'b1;
    end
    cyc++;
    @(negedge clk_i);
    branch_i = 1'b0;
    check_value("fetch_valid", fetch_valid_o, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      check_value("fetch_addr", fetch_addr_o, fifo_q[0].addr);
      check_value("fetch_rdata", fetch_rdata_o, fifo_q[0].data);
    end
    check_value("busy", busy_o, mem_q.size() != 0);
    if (hold_flag) begin
      check_value("req_held", instr_req_o, 1);
      check_value("addr_held", instr_addr_o, hold_addr);
    end
    check_value("no_overflow", (mem_q.size() + fifo_q.size()) <= DEPTH, 1);
    if (instr_req_o) check_value("addr_align", instr_addr_o & 32'd3, 0);
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (pop_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check_value(tag, pop_log.size(), n);
  endtask

  task automatic branch_to(input logic [31:0] a);
    branch_i = 1'b1;
    branch_addr_i = a;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    gnt_pct = 100;
    rv_pct = 100;

    // Straight-line fetch with zero-wait memory, first valid three cycles after the redirect
    do_reset();
    gnt_pct = 100; rv_pct = 100; fetch_ready_i = 1'b1; req_i = 1'b1;
    branch_to(32'h80);
    check_value("t1_valid_c1", fetch_valid_o, 0);
    cycle();
    check_value("t1_valid_c2", fetch_valid_o, 0);
    cycle();
    check_value("t1_valid_c3", fetch_valid_o, 1);
    check_value("t1_addr_c3", fetch_addr_o, 32'h80);
    wait_pops(3, 30, "t1_pops");
    for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
      check_value("t1_seq_addr", pop_log[i].addr, 32'h80 + 32'(4 * i));
      check_value("t1_seq_data", pop_log[i].data, 32'h120 + 32'(4 * i));
    end

    // Back-pressure: FIFO fills, requests stop, resume one cycle after the first pop
    do_reset();
    fetch_ready_i = 1'b0; req_i = 1'b1;
    branch_to(32'h80);
    repeat (8) cycle();
    check_value("t2_req_stopped", instr_req_o, 0);
    check_value("t2_head", fetch_addr_o, 32'h80);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_value("t2_req_still_0", instr_req_o, 0);
    end
    fetch_ready_i = 1'b1;
    cycle();
    check_value("t2_resume", instr_req_o, 1);
    check_value("t2_second", fetch_addr_o, 32'h84);
    wait_pops(3, 30, "t2_pops");

    // Redirect while a request waits for grant: address held, stale response dropped
    do_reset();
    fetch_ready_i = 1'b1; req_i = 1'b1; gnt_pct = 0;
    branch_to(32'h80);
    check_value("t3_req", instr_req_o, 1);
    check_value("t3_addr0", instr_addr_o, 32'h80);
    cycle();
    branch_to(32'h200);
    check_value("t3_addr1", instr_addr_o, 32'h80);
    cycle();
    check_value("t3_addr2", instr_addr_o, 32'h80);
    gnt_pct = 100;
    cycle();
    check_value("t3_next_req", instr_req_o, 1);
    check_value("t3_next_addr", instr_addr_o, 32'h200);
    wait_pops(1, 30, "t3_pops");
    if (pop_log.size() > 0) check_value("t3_first", pop_log[0].addr, 32'h200);

    // Two in flight, redirect coinciding with the first response
    do_reset();
    fetch_ready_i = 1'b1; req_i = 1'b1; gnt_pct = 100; rv_pct = 0;
    branch_to(32'h100);
    cycle();
    cycle();
    check_value("t4_busy_out2", busy_o, 1);
    check_value("t4_req_idle", instr_req_o, 0);
    gnt_pct = 0; rv_pct = 100;
    branch_to(32'h40);
    check_value("t4_busy_disc", busy_o, 1);
    check_value("t4_valid", fetch_valid_o, 0);
    cycle();
    check_value("t4_busy_fall", busy_o, 0);
    check_value("t4_req_new", instr_addr_o, 32'h40);
    gnt_pct = 100;
    wait_pops(2, 30, "t4_pops");
    if (pop_log.size() > 1) begin
      check_value("t4_first", pop_log[0].addr, 32'h40);
      check_value("t4_second", pop_log[1].addr, 32'h44);
    end

    // Address wrap at the top of the address space
    do_reset();
    fetch_ready_i = 1'b1; req_i = 1'b1; gnt_pct = 70; rv_pct = 70;
    branch_to(32'hFFFF_FFF8);
    wait_pops(3, 80, "t5_pops");
    if (pop_log.size() > 2) begin
      check_value("t5_a0", pop_log[0].addr, 32'hFFFF_FFF8);
      check_value("t5_a1", pop_log[1].addr, 32'hFFFF_FFFC);
      check_value("t5_a2", pop_log[2].addr, 32'h0000_0000);
      check_value("t5_d2", pop_log[2].data, 32'h0000_00A0);
    end

    // Asynchronous reset with two outstanding
    do_reset();
    fetch_ready_i = 1'b1; req_i = 1'b1; gnt_pct = 100; rv_pct = 0;
    branch_to(32'h300);
    cycle();
    cycle();
    check_value("t6_busy_before", busy_o, 1);
    #2;
    rstn_i = 1'b0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    #1;
    check_all_zero("t6_async");
    clear_model();
    req_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    rv_pct = 100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_value("t6_no_issue", instr_req_o, 0);
    end
    req_i = 1'b1;
    branch_to(32'h300);
    wait_pops(2, 30, "t6_pops");
    if (pop_log.size() > 0) check_value("t6_first", pop_log[0].addr, 32'h300);

    // Randomized traffic against the model
    do_reset();
    req_i = 1'b1; fetch_ready_i = 1'b1; gnt_pct = 60; rv_pct = 60;
    branch_to(32'h1000);
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        gnt_pct = int'($urandom_range(30, 100));
        rv_pct  = int'($urandom_range(30, 100));
      end
      req_i = ($urandom_range(9) != 0);
      fetch_ready_i = ($urandom_range(9) < 7);
      if ($urandom_range(19) == 0) begin
        branch_i = 1'b1;
        if ($urandom_range(3) == 0)
          branch_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else
          branch_addr_i = $urandom;
      end
      cycle();
    end
    check_value("rand_progress", pop_log.size() > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
